// File: rtl/ir_letter_queue_if.sv
// Handshake bundle for ir_letter_queue.
//   slave  : the queue itself (takes enigma letters and tx busy, drives tx and status)
//   master : the surrounding logic / bench (drives letters and tx busy, observes the rest)
// Signals:
//   data_valid_in, data_in : enigma letter stream (captured on valid rise)
//   tx_busy_in             : IR transmitter busy
//   tx_valid_out, tx_data_out : one-cycle issue pulse and held letter to the transmitter
//   count_out, empty_out, full_out, overflow_out : occupancy / debug status
interface ir_letter_queue_if #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  data_valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  tx_busy_in;
  logic                  tx_valid_out;
  logic [DATA_WIDTH-1:0] tx_data_out;
  logic [CW-1:0]         count_out;
  logic                  empty_out;
  logic                  full_out;
  logic                  overflow_out;

  modport slave (
    input  data_valid_in, data_in, tx_busy_in,
    output tx_valid_out, tx_data_out, count_out, empty_out, full_out, overflow_out
  );

  modport master (
    output data_valid_in, data_in, tx_busy_in,
    input  tx_valid_out, tx_data_out, count_out, empty_out, full_out, overflow_out
  );
endinterface

// File: rtl/ir_letter_queue.sv
// Letter queue between the enigma encoder and the IR transmitter.
// Captures a letter on each rising edge of data_valid_in into a circular
// buffer and releases them one at a time, waiting for the transmitter to
// start (or time out) and finish each letter before issuing the next.
// Ports:
//   clk_in   : 100 MHz system clock
//   rst_n_in : asynchronous active-low reset
//   q        : ir_letter_queue_if.slave (letter in, tx handshake out, status)
module ir_letter_queue #(
  parameter int DATA_WIDTH    = 5,
  parameter int DEPTH         = 1024,
  parameter int GAP_CYCLES    = 0,
  parameter int START_TIMEOUT = 16
) (
  input  logic clk_in,
  input  logic rst_n_in,
  ir_letter_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 2);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, GAP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  prev_valid;
  logic                  wr_ev, pop, wr_ok;
  state_t                state;
  logic [TW-1:0]         start_tmr;
  logic [GW-1:0]         gap_tmr;

  // A pop in the same cycle frees a slot, so a write while full is still
  // accepted; pop only looks at the registered count, so an empty queue
  // never pops the letter being written.
  always_comb begin
    wr_ev     = q.data_valid_in & ~prev_valid;
    pop       = (state == IDLE) && (count != '0);
    wr_ok     = wr_ev && ((count != FULL_CNT) || pop);
    count_nxt = count;
    case ({wr_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign q.count_out = count;

  // Simple dual-port RAM, registered read, no reset so it maps to BRAM.
  // The read address is rd_ptr before the pop increments it, so the popped
  // letter is in rd_data during LOAD. Same-address write/read returns old data.
  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_ptr] <= q.data_in;
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_valid     <= 1'b1;  // ignore a valid already high at release
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      q.empty_out    <= 1'b1;
      q.full_out     <= 1'b0;
      q.overflow_out <= 1'b0;
    end else begin
      prev_valid  <= q.data_valid_in;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      q.empty_out <= (count_nxt == '0);
      q.full_out  <= (count_nxt == FULL_CNT);
      if (wr_ev && !wr_ok) q.overflow_out <= 1'b1;
    end
  end

  // Issue FSM. The issue itself happens on the LOAD exit edge, so the
  // pulse is high while the FSM sits in WAIT_START's first cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      start_tmr      <= '0;
      gap_tmr        <= '0;
      q.tx_valid_out <= 1'b0;
      q.tx_data_out  <= '0;
    end else begin
      case (state)
        IDLE: if (count != '0) state <= LOAD;
        LOAD: begin
          q.tx_data_out  <= rd_data;
          q.tx_valid_out <= 1'b1;
          start_tmr      <= '0;
          state          <= WAIT_START;
        end
        WAIT_START: begin
          q.tx_valid_out <= 1'b0;
          if (q.tx_busy_in) begin
            state <= WAIT_DONE;
          end else if (start_tmr == TW'(START_TIMEOUT - 1)) begin
            // transmitter never started: treat the letter as sent
            gap_tmr <= '0;
            state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            start_tmr <= start_tmr + 1'b1;
          end
        end
        WAIT_DONE: if (!q.tx_busy_in) begin
          gap_tmr <= '0;
          state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          if (gap_tmr == GW'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_tmr <= gap_tmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ir_letter_queue.sv
// Scoreboard bench for ir_letter_queue: instance A (DEPTH 8, GAP 2) covers
// latency, spacing, wrap and reset; instance B (DEPTH 4) covers full/overflow.
module tb_ir_letter_queue;
  localparam int DW = 5;
  localparam int TO = 16;
  localparam int GA = 2;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ir_letter_queue_if #(.DATA_WIDTH(DW), .DEPTH(8)) ifa();
  ir_letter_queue_if #(.DATA_WIDTH(DW), .DEPTH(4)) ifb();

  ir_letter_queue #(.DATA_WIDTH(DW), .DEPTH(8), .GAP_CYCLES(GA), .START_TIMEOUT(TO))
    dut_a (.clk_in(clk), .rst_n_in(rst_n), .q(ifa));
  ir_letter_queue #(.DATA_WIDTH(DW), .DEPTH(4), .GAP_CYCLES(0), .START_TIMEOUT(TO))
    dut_b (.clk_in(clk), .rst_n_in(rst_n), .q(ifb));

  int sb_a[$];
  int sb_b[$];
  int issues_a = 0, issues_b = 0;
  int last_a = -1;
  int exp_gap_a = 0;
  int busy_len_a = 5;
  bit stall_b = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // issue monitors: scoreboard data, pulse width, issue spacing
  initial begin
    bit prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.tx_valid_out) begin
        issues_a++;
        chk("a_one_cycle", int'(prev_v), 0);
        chk("a_sb_nonempty", int'(sb_a.size() > 0), 1);
        if (sb_a.size() > 0) chk("a_data", int'(ifa.tx_data_out), sb_a.pop_front());
        if (exp_gap_a > 0 && last_a >= 0) chk("a_spacing", cyc - last_a, exp_gap_a);
        last_a = cyc;
      end
      prev_v = ifa.tx_valid_out;
    end
  end

  initial begin
    bit prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.tx_valid_out) begin
        issues_b++;
        chk("b_one_cycle", int'(prev_v), 0);
        chk("b_sb_nonempty", int'(sb_b.size() > 0), 1);
        if (sb_b.size() > 0) chk("b_data", int'(ifb.tx_data_out), sb_b.pop_front());
      end
      prev_v = ifb.tx_valid_out;
    end
  end

  // transmitter models: busy rises after the edge that samples the pulse
  initial begin
    ifa.tx_busy_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.tx_valid_out && busy_len_a > 0) begin
        @(posedge clk);
        #1 ifa.tx_busy_in = 1'b1;
        repeat (busy_len_a) @(posedge clk);
        #1 ifa.tx_busy_in = 1'b0;
      end
    end
  end

  initial begin
    ifb.tx_busy_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.tx_valid_out) begin
        @(posedge clk);
        #1 ifb.tx_busy_in = 1'b1;
        repeat (3) @(posedge clk);
        while (stall_b) @(posedge clk);
        #1 ifb.tx_busy_in = 1'b0;
      end
    end
  end

  // one letter: valid high for hi cycles then low for one
  task automatic put(input int sel, input int letter, input int hi, input bit push);
    if (sel == 0) begin
      ifa.data_in = DW'(letter);
      ifa.data_valid_in = 1'b1;
      if (push) sb_a.push_back(letter);
      repeat (hi) @(negedge clk);
      ifa.data_valid_in = 1'b0;
    end else begin
      ifb.data_in = DW'(letter);
      ifb.data_valid_in = 1'b1;
      if (push) sb_b.push_back(letter);
      repeat (hi) @(negedge clk);
      ifb.data_valid_in = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_issues(input int sel, input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if ((sel == 0 ? issues_a : issues_b) >= target) break;
      @(negedge clk);
    end
    chk(tag, (sel == 0 ? issues_a : issues_b), target);
  endtask

  initial begin
    int wr_cyc, base;
    rst_n = 1'b0;
    ifa.data_valid_in = 1'b0; ifa.data_in = '0;
    ifb.data_valid_in = 1'b0; ifb.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_empty", int'(ifa.empty_out), 1);
    chk("rst_count", int'(ifa.count_out), 0);
    chk("rst_full", int'(ifa.full_out), 0);
    chk("rst_txv", int'(ifa.tx_valid_out), 0);
    chk("rst_ovf", int'(ifb.overflow_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single letter with a 3-cycle valid pulse
    ifa.data_in = 5'd2; ifa.data_valid_in = 1'b1; sb_a.push_back(2);
    @(negedge clk); wr_cyc = cyc;
    chk("t1_count1", int'(ifa.count_out), 1);
    @(negedge clk);
    chk("t1_count0", int'(ifa.count_out), 0);
    @(negedge clk);
    ifa.data_valid_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("t1_issues", issues_a, 1);
    chk("t1_latency", last_a - wr_cyc, 2);

    // burst with 50-cycle busy
    busy_len_a = 50; last_a = -1; exp_gap_a = 50 + 4 + GA;
    for (int i = 0; i < 4; i++) put(0, i, 1, 1);
    wait_issues(0, 5, 400, "t2_issues");
    repeat (60) @(negedge clk);
    chk("t2_empty", int'(ifa.empty_out), 1);

    // transmitter never starts: timeout path
    busy_len_a = 0; last_a = -1; exp_gap_a = TO + 2 + GA;
    for (int i = 0; i < 3; i++) put(0, 20 + i, 1, 1);
    wait_issues(0, 8, 200, "t3_issues");
    repeat (40) @(negedge clk);

    // write lands on the pop edge at count 2, over 2*DEPTH letters
    last_a = -1; exp_gap_a = 0;
    put(0, 4, 1, 1); put(0, 5, 1, 1); put(0, 6, 1, 1);
    exp_gap_a = TO + 2 + GA;
    chk("t5_pre_count", int'(ifa.count_out), 2);
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 100; k++) begin
        if (last_a >= 0 && cyc == last_a + TO + GA) break;
        @(negedge clk);
      end
      ifa.data_in = DW'((7 + i) % 26); ifa.data_valid_in = 1'b1; sb_a.push_back((7 + i) % 26);
      @(negedge clk);
      chk("t5_count_hold", int'(ifa.count_out), 2);
      ifa.data_valid_in = 1'b0;
    end
    wait_issues(0, 27, 200, "t5_issues");
    repeat (25) @(negedge clk);
    chk("t5_empty", int'(ifa.empty_out), 1);

    // DEPTH=4 with a stalled transmitter
    put(1, 9, 1, 1);
    for (int i = 0; i < 50 && !ifb.tx_busy_in; i++) @(negedge clk);
    chk("t4_stalled", int'(ifb.tx_busy_in), 1);
    for (int i = 0; i < 6; i++) begin
      put(1, 10 + i, 1, i < 4);
      if (i == 3) begin
        chk("t4_full", int'(ifb.full_out), 1);
        chk("t4_count4", int'(ifb.count_out), 4);
        chk("t4_no_ovf", int'(ifb.overflow_out), 0);
      end
      if (i >= 4) begin
        chk("t4_ovf", int'(ifb.overflow_out), 1);
        chk("t4_count_keep", int'(ifb.count_out), 4);
      end
    end
    stall_b = 1'b0;
    wait_issues(1, 5, 300, "t4_issues");
    repeat (10) @(negedge clk);
    chk("t4_ovf_sticky", int'(ifb.overflow_out), 1);
    chk("t4_empty", int'(ifb.empty_out), 1);

    // reset during WAIT_DONE with valid held high across release
    busy_len_a = 40; exp_gap_a = 0;
    put(0, 5, 1, 1);
    for (int i = 0; i < 50 && !ifa.tx_busy_in; i++) @(negedge clk);
    chk("t6_busy", int'(ifa.tx_busy_in), 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    ifa.data_valid_in = 1'b1; ifa.data_in = 5'd7;
    sb_a.delete(); sb_b.delete();
    #1;
    chk("t6_txd", int'(ifa.tx_data_out), 0);
    chk("t6_txv", int'(ifa.tx_valid_out), 0);
    chk("t6_empty", int'(ifa.empty_out), 1);
    chk("t6_count", int'(ifa.count_out), 0);
    chk("t6_full", int'(ifa.full_out), 0);
    chk("t6_ovf_b", int'(ifb.overflow_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = issues_a;
    repeat (5) @(negedge clk);
    chk("t6_no_write", int'(ifa.count_out), 0);
    ifa.data_valid_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_no_issue", issues_a, base);
    put(0, 17, 1, 1);
    wait_issues(0, base + 1, 200, "t6_capture");
    repeat (60) @(negedge clk);
    chk("t6_end_empty", int'(ifa.empty_out), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
